// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: show-ahead byte FIFO feeding the uart transmitter handshake.
// Reports fill level, almost-full, and a sticky overflow flag. Status flags
// are decoded only from the registered count, so wr_ready and tx_valid have
// no combinational path from wr_valid or tx_ready.
module uart_tx_fifo #(
   parameter int DATA_W      = 8,
   parameter int DEPTH       = 16,
   parameter int AFULL_LEVEL = 12
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [DATA_W-1:0]          wr_data,
   input  logic                       wr_valid,
   output logic                       wr_ready,
   input  logic                       flush,
   input  logic                       clr_ovf,
   output logic [DATA_W-1:0]          tx_data,
   output logic                       tx_valid,
   input  logic                       tx_ready,
   output logic [$clog2(DEPTH+1)-1:0] count,
   output logic                       empty,
   output logic                       full,
   output logic                       almost_full,
   output logic                       overflow
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH+1);

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]  count_q, count_d;
   logic              ovf_q, ovf_d;
   logic              push, pop;

   // Status decode from registered count only
   always_comb begin
      empty       = (count_q == '0);
      full        = (count_q == CNT_W'(DEPTH));
      almost_full = (count_q >= CNT_W'(AFULL_LEVEL));
      wr_ready    = ~full;
      tx_valid    = ~empty;
      count       = count_q;
      overflow    = ovf_q;
      tx_data     = mem_q[rd_ptr_q];
   end

   // Next-state: flush discards everything and masks any push/pop that cycle;
   // pointers wrap naturally because DEPTH is a power of two.
   always_comb begin
      push     = wr_valid & wr_ready & ~flush;
      pop      = tx_valid & tx_ready & ~flush;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush) begin
         rd_ptr_d = wr_ptr_q;
         count_d  = '0;
      end else begin
         if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
         if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
         case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
         endcase
      end
      // A write attempt while full wins over a same-cycle clear
      ovf_d = ovf_q;
      if (wr_valid & full) ovf_d = 1'b1;
      else if (clr_ovf)    ovf_d = 1'b0;
   end

   // Control state with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         ovf_q    <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         ovf_q    <= ovf_d;
      end
   end

   // Storage array; contents are intentionally not reset
   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= wr_data;
   end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: a vector table for simple single-cycle
// behaviour, then hand-written sequences for fill/overflow/drain, wrap,
// flush and mid-burst reset.
module tb_uart_tx_fifo;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [7:0] wr_data = 8'h00;
   logic       wr_valid = 1'b0;
   logic       wr_ready;
   logic       flush = 1'b0;
   logic       clr_ovf = 1'b0;
   logic [7:0] tx_data;
   logic       tx_valid;
   logic       tx_ready = 1'b0;
   logic [4:0] count;
   logic       empty, full, almost_full, overflow;

   int n_vec = 0;
   int n_err = 0;

   uart_tx_fifo #(.DATA_W(8), .DEPTH(16), .AFULL_LEVEL(12)) dut (
      .clk(clk), .rst(rst), .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
      .flush(flush), .clr_ovf(clr_ovf), .tx_data(tx_data), .tx_valid(tx_valid),
      .tx_ready(tx_ready), .count(count), .empty(empty), .full(full),
      .almost_full(almost_full), .overflow(overflow)
   );

   always #5 clk = ~clk;

   typedef struct {
      string      name;
      bit         r, wv, tr, fl, co;
      logic [7:0] wd;
      int         ecnt;
      bit         eovf;
      bit         chk;
      logic [7:0] etd;
   } vec_t;

   // Apply one cycle of inputs, then sample 1 time unit after the edge
   task automatic step(input bit r, input bit wv, input logic [7:0] wd,
                       input bit tr, input bit fl, input bit co);
      rst = r; wr_valid = wv; wr_data = wd; tx_ready = tr; flush = fl; clr_ovf = co;
      @(posedge clk);
      #1;
   endtask

   // Flags are checked against their definitions for a DEPTH=16, AFULL=12 FIFO
   task automatic check(input string nm, input int ecnt, input bit eovf,
                        input bit chk, input logic [7:0] etd);
      bit ok;
      n_vec++;
      ok = (int'(count) == ecnt) && (empty == (ecnt == 0)) && (full == (ecnt == 16)) &&
           (almost_full == (ecnt >= 12)) && (wr_ready == (ecnt != 16)) &&
           (tx_valid == (ecnt != 0)) && (overflow == eovf) && (!chk || tx_data == etd);
      if (!ok) begin
         n_err++;
         $display("FAIL %s: got cnt=%0d e=%b f=%b af=%b wr=%b tv=%b ovf=%b td=%h ; want cnt=%0d ovf=%b td=%h(chk=%b)",
                  nm, count, empty, full, almost_full, wr_ready, tx_valid, overflow, tx_data,
                  ecnt, eovf, etd, chk);
      end
   endtask

   vec_t tbl[$];

   initial begin
      //            name          r  wv tr fl co wd     cnt ovf chk td
      tbl.push_back('{"rst0",      1, 0, 0, 0, 0, 8'h00, 0, 0, 0, 8'h00});
      tbl.push_back('{"rst1",      1, 1, 1, 0, 0, 8'h12, 0, 0, 0, 8'h00});
      tbl.push_back('{"rst2",      1, 0, 0, 0, 0, 8'h00, 0, 0, 0, 8'h00});
      tbl.push_back('{"rst3",      1, 0, 0, 0, 0, 8'h00, 0, 0, 0, 8'h00});
      tbl.push_back('{"rst4",      1, 0, 0, 0, 0, 8'h00, 0, 0, 0, 8'h00});
      tbl.push_back('{"push_a5",   0, 1, 0, 0, 0, 8'hA5, 1, 0, 1, 8'hA5});
      tbl.push_back('{"hold_a5",   0, 0, 0, 0, 0, 8'h00, 1, 0, 1, 8'hA5});
      tbl.push_back('{"pop_a5",    0, 0, 1, 0, 0, 8'h00, 0, 0, 0, 8'h00});
      tbl.push_back('{"pop_empty", 0, 0, 1, 0, 0, 8'h00, 0, 0, 0, 8'h00});
      tbl.push_back('{"push_11",   0, 1, 0, 0, 0, 8'h11, 1, 0, 1, 8'h11});
      tbl.push_back('{"pushpop22", 0, 1, 1, 0, 0, 8'h22, 1, 0, 1, 8'h22});
      tbl.push_back('{"pop_22",    0, 0, 1, 0, 0, 8'h00, 0, 0, 0, 8'h00});
      tbl.push_back('{"clr_idle",  0, 0, 0, 0, 1, 8'h00, 0, 0, 0, 8'h00});

      foreach (tbl[i]) begin
         step(tbl[i].r, tbl[i].wv, tbl[i].wd, tbl[i].tr, tbl[i].fl, tbl[i].co);
         check(tbl[i].name, tbl[i].ecnt, tbl[i].eovf, tbl[i].chk, tbl[i].etd);
      end

      // Fill 00..0F; head stays 00, almost_full at 12, full at 16
      for (int i = 0; i < 16; i++) begin
         step(0, 1, 8'(i), 0, 0, 0);
         check("fill", i + 1, 0, 1, 8'h00);
      end
      // Write while full with clr_ovf: set wins, byte dropped
      step(0, 1, 8'hEE, 0, 0, 1);
      check("ovf_set", 16, 1, 1, 8'h00);
      step(0, 0, 8'h00, 0, 0, 1);
      check("ovf_clr", 16, 0, 1, 8'h00);
      // Write+pop while full: no pass-through, overflow set, one byte leaves
      step(0, 1, 8'hEE, 1, 0, 0);
      check("full_wr_pop", 15, 1, 1, 8'h01);
      for (int i = 1; i < 16; i++) begin
         check("drain_head", 16 - i, 1, 1, 8'(i));
         step(0, 0, 8'h00, 1, 0, 0);
      end
      check("drained", 0, 1, 0, 8'h00);
      step(0, 0, 8'h00, 0, 0, 1);
      check("clr_after_drain", 0, 0, 0, 8'h00);

      // Count 5, then 20 simultaneous push/pop cycles across the pointer wrap
      for (int i = 0; i < 5; i++) step(0, 1, 8'(8'h40 + i), 0, 0, 0);
      check("fill5", 5, 0, 1, 8'h40);
      for (int k = 1; k <= 20; k++) begin
         step(0, 1, 8'(8'h44 + k), 1, 0, 0);
         check("steady", 5, 0, 1, 8'(8'h40 + k));
      end

      // Queue now holds 54..58; fill to 16, overflow, pop down to 9
      for (int i = 0; i < 11; i++) step(0, 1, 8'(8'h59 + i), 0, 0, 0);
      check("refill", 16, 0, 1, 8'h54);
      step(0, 1, 8'hEE, 0, 0, 0);
      check("ovf2", 16, 1, 1, 8'h54);
      for (int i = 0; i < 7; i++) step(0, 0, 8'h00, 1, 0, 0);
      check("cnt9", 9, 1, 1, 8'h5B);
      // Flush masks the same-cycle push and pop; overflow survives
      step(0, 1, 8'h77, 1, 1, 0);
      check("flush", 0, 1, 0, 8'h00);
      step(0, 1, 8'h3C, 0, 0, 0);
      check("post_flush", 1, 1, 1, 8'h3C);
      step(0, 0, 8'h00, 1, 0, 0);
      check("pop_3c", 0, 1, 0, 8'h00);

      // Mid-burst reset with count 7 and overflow still set
      for (int i = 0; i < 7; i++) step(0, 1, 8'(8'hA0 + i), 0, 0, 0);
      check("cnt7", 7, 1, 1, 8'hA0);
      step(1, 1, 8'hBB, 1, 0, 0);
      check("mid_rst", 0, 0, 0, 8'h00);
      step(0, 1, 8'h5A, 0, 0, 0);
      check("post_rst", 1, 0, 1, 8'h5A);
      step(0, 1, 8'hC3, 0, 0, 0);
      check("post_rst2", 2, 0, 1, 8'h5A);
      step(0, 0, 8'h00, 1, 0, 0);
      check("post_rst_pop", 1, 0, 1, 8'hC3);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
